// File: rtl/tensor_acc_pkg.sv
// Shared types and constants for the tensor accumulator stage of the Mini SPU datapath.
// A beat count of zero on len selects the largest count, 2^LEN_W beats.
package tensor_acc_pkg;

    localparam int ACC_W_DEFAULT = 8;
    localparam int LEN_W_DEFAULT = 4;

    localparam bit LEN_ZERO_MEANS_MAX = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

endpackage

// File: rtl/tensor_accumulator_sat_add.sv
// Adds a 4-bit product to an ACC_W-bit lane value and clamps the result at 2^ACC_W-1.
// o_sat is high whenever the clamp was applied.
module sat_add #(
    parameter int ACC_W = 8
) (
    input  logic [ACC_W-1:0] i_acc,
    input  logic [3:0]       i_addend,
    output logic [ACC_W-1:0] o_sum,
    output logic             o_sat
);

    logic [ACC_W:0] w_wide;

    // One spare bit catches the carry that marks an overflow.
    assign w_wide = {1'b0, i_acc} + (ACC_W + 1)'(i_addend);
    assign o_sat  = w_wide[ACC_W];
    assign o_sum  = o_sat ? '1 : w_wide[ACC_W-1:0];

endmodule

// File: rtl/tensor_accumulator.sv
// Accumulates high and low product lanes over len beats into saturating accumulators.
// It then holds both sums and their total on a valid/ready output until the result is taken.
module tensor_accumulator
    import tensor_acc_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEFAULT,
    parameter int LEN_W = LEN_W_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic [LEN_W-1:0] len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       tensor_high,
    input  logic [3:0]       tensor_low,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] acc_high,
    output logic [ACC_W-1:0] acc_low,
    output logic [ACC_W:0]   acc_sum,
    output logic             sat
);

    state_t             r_state;
    logic [LEN_W-1:0]   r_remaining;
    logic [ACC_W-1:0]   r_accHigh;
    logic [ACC_W-1:0]   r_accLow;
    logic               r_sat;

    logic [LEN_W-1:0]   w_firstRemaining;
    logic [ACC_W-1:0]   w_sumHigh;
    logic [ACC_W-1:0]   w_sumLow;
    logic               w_satHigh;
    logic               w_satLow;

    sat_add #(.ACC_W(ACC_W)) u_addHigh (
        .i_acc    (r_accHigh),
        .i_addend (tensor_high),
        .o_sum    (w_sumHigh),
        .o_sat    (w_satHigh)
    );

    sat_add #(.ACC_W(ACC_W)) u_addLow (
        .i_acc    (r_accLow),
        .i_addend (tensor_low),
        .o_sum    (w_sumLow),
        .o_sat    (w_satLow)
    );

    // Beats still owed after the first one; len==0 asks for the maximum count.
    always_comb begin
        w_firstRemaining = '0;
        if (len == '0) begin
            w_firstRemaining = LEN_ZERO_MEANS_MAX ? '1 : '0;
        end else begin
            w_firstRemaining = len - LEN_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_remaining <= '0;
            r_accHigh   <= '0;
            r_accLow    <= '0;
            r_sat       <= 1'b0;
        end else if (clear) begin
            r_state     <= IDLE;
            r_remaining <= '0;
            r_accHigh   <= '0;
            r_accLow    <= '0;
            r_sat       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_accHigh   <= ACC_W'(tensor_high);
                        r_accLow    <= ACC_W'(tensor_low);
                        r_sat       <= 1'b0;
                        r_remaining <= w_firstRemaining;
                        r_state     <= (w_firstRemaining == '0) ? HOLD : ACCUM;
                    end
                end
                ACCUM: begin
                    if (in_valid) begin
                        r_accHigh   <= w_sumHigh;
                        r_accLow    <= w_sumLow;
                        r_sat       <= r_sat | w_satHigh | w_satLow;
                        r_remaining <= r_remaining - LEN_W'(1);
                        if (r_remaining == LEN_W'(1)) begin
                            r_state <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (r_state != HOLD);
    assign out_valid = (r_state == HOLD);
    assign acc_high  = r_accHigh;
    assign acc_low   = r_accLow;
    assign acc_sum   = {1'b0, r_accHigh} + {1'b0, r_accLow};
    assign sat       = r_sat;

endmodule
